// File: rtl/rgb2hsv.sv
// rgb2hsv: 12-stage RGB to HSV converter (8-bit components).
// Stages: 0 input reg, 1 max/min/sector, 2 products, 3..10 restoring
// divider (one quotient bit each, two dividers side by side for H and S),
// 11 saturation/assembly into the output register.
//
// Handshake: a beat moves on every edge where run = in_ready | ~valid[11].
// in_ready means downstream takes the beat on out_data this edge; out_ready
// (= run) means this block takes in_data this edge. A beat is transferred
// on an edge where its valid and the matching ready are both 1. When run is
// low, every pipeline register, including out_data/out_user, holds.
module rgb2hsv #(
  parameter int RGB_DEPTH = 8,
  parameter int HSV_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [2:0][RGB_DEPTH-1:0]     in_data,
  input  logic [7:0]                    in_user,
  output logic                          out_valid,
  output logic [2:0][HSV_DEPTH-1:0]     out_data,
  output logic [7:0]                    out_user,
  input  logic                          in_ready,
  output logic                          out_ready
);

  localparam int L  = 12;
  localparam int ND = 8;

  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;
  localparam logic [2:0] S5 = 3'd5;

  // One restoring-divider step on {remainder, unconsumed numerator bits /
  // quotient bits}. The remainder never reaches 256, so the 8-bit modular
  // subtraction is exact.
  function automatic logic [15:0] div_step(input logic [15:0] acc,
                                           input logic [7:0]  d);
    logic [8:0] t;
    logic       ge;
    t  = acc[15:7];
    ge = (t >= {1'b0, d});
    div_step = {(ge ? (t[7:0] - d) : t[7:0]), acc[6:0], ge};
  endfunction

  // Final divider step: only the quotient byte is needed afterwards.
  function automatic logic [7:0] div_last(input logic [15:0] acc,
                                          input logic [7:0]  d);
    div_last = {acc[6:0], (acc[15:7] >= {1'b0, d})};
  endfunction

  logic            run;
  logic [L-1:0]    valid_q, valid_d;
  logic [7:0]      user_q [L];
  logic [7:0]      user_d [L];

  // stage 0
  logic [7:0]      r0_q, g0_q, b0_q, r0_d, g0_d, b0_d;
  // stage 1
  logic [7:0]      max1_q, delta1_q, num1_q, max1_d, delta1_d, num1_d;
  logic [2:0]      sec1_q, sec1_d;
  // stages 2..10: index p lives in pipeline stage p+2
  logic [15:0]     hacc_q [ND];
  logic [15:0]     hacc_d [ND];
  logic [15:0]     sacc_q [ND];
  logic [15:0]     sacc_d [ND];
  logic [7:0]      ddel_q [ND+1];
  logic [7:0]      ddel_d [ND+1];
  logic [7:0]      dmax_q [ND+1];
  logic [7:0]      dmax_d [ND+1];
  logic [2:0]      dsec_q [ND+1];
  logic [2:0]      dsec_d [ND+1];
  logic [7:0]      hq_q, hq_d, sq_q, sq_d;
  // stage 11
  logic [2:0][7:0] out_data_q, out_data_d;

  // combinational helpers
  logic [7:0]      mx, mn, num_c;
  logic [2:0]      sec_c;
  logic [7:0]      base_c, cap_c, frac_c, h_c, s_c;

  assign run       = in_ready | ~valid_q[L-1];
  assign out_ready = run;
  assign out_valid = valid_q[L-1];
  assign out_data  = out_data_q;
  assign out_user  = user_q[L-1];

  // Max/min and hue sector (first match wins) from the stage-0 pixel.
  always_comb begin
    mx    = r0_q;
    mn    = r0_q;
    sec_c = S0;
    num_c = 8'd0;
    if (g0_q > mx) mx = g0_q;
    if (b0_q > mx) mx = b0_q;
    if (g0_q < mn) mn = g0_q;
    if (b0_q < mn) mn = b0_q;
    if (r0_q >= g0_q && r0_q >= b0_q) begin
      if (g0_q >= b0_q) begin sec_c = S0; num_c = g0_q - b0_q; end
      else              begin sec_c = S5; num_c = r0_q - b0_q; end
    end else if (g0_q >= b0_q) begin
      if (b0_q >= r0_q) begin sec_c = S2; num_c = b0_q - r0_q; end
      else              begin sec_c = S1; num_c = g0_q - r0_q; end
    end else begin
      if (r0_q >= g0_q) begin sec_c = S4; num_c = r0_q - g0_q; end
      else              begin sec_c = S3; num_c = b0_q - g0_q; end
    end
  end

  // Saturate the hue fraction, add the sector base, and zero H/S for greys.
  always_comb begin
    case (dsec_q[ND])
      S1:      base_c = 8'd43;
      S2:      base_c = 8'd86;
      S3:      base_c = 8'd129;
      S4:      base_c = 8'd172;
      S5:      base_c = 8'd215;
      default: base_c = 8'd0;
    endcase
    cap_c  = (dsec_q[ND] == S5) ? 8'd40 : 8'd42;
    frac_c = (hq_q > cap_c) ? cap_c : hq_q;
    h_c    = (ddel_q[ND] == 8'd0) ? 8'd0 : (base_c + frac_c);
    s_c    = (ddel_q[ND] == 8'd0) ? 8'd0 : sq_q;
  end

  // Next-state for every stage: advance on run, load data only behind a valid beat.
  always_comb begin
    valid_d    = valid_q;
    user_d     = user_q;
    r0_d       = r0_q;
    g0_d       = g0_q;
    b0_d       = b0_q;
    max1_d     = max1_q;
    delta1_d   = delta1_q;
    num1_d     = num1_q;
    sec1_d     = sec1_q;
    hacc_d     = hacc_q;
    sacc_d     = sacc_q;
    ddel_d     = ddel_q;
    dmax_d     = dmax_q;
    dsec_d     = dsec_q;
    hq_d       = hq_q;
    sq_d       = sq_q;
    out_data_d = out_data_q;
    if (run) begin
      valid_d = {valid_q[L-2:0], in_valid};
      if (in_valid) begin
        r0_d      = in_data[2];
        g0_d      = in_data[1];
        b0_d      = in_data[0];
        user_d[0] = in_user;
      end
      if (valid_q[0]) begin
        max1_d    = mx;
        delta1_d  = mx - mn;
        num1_d    = num_c;
        sec1_d    = sec_c;
        user_d[1] = user_q[0];
      end
      if (valid_q[1]) begin
        hacc_d[0] = {8'd0, num1_q} * 16'd43;
        sacc_d[0] = {8'd0, delta1_q} * 16'd255;
        ddel_d[0] = delta1_q;
        dmax_d[0] = max1_q;
        dsec_d[0] = sec1_q;
        user_d[2] = user_q[1];
      end
      for (int p = 0; p < ND - 1; p++) begin
        if (valid_q[p+2]) begin
          hacc_d[p+1] = div_step(hacc_q[p], ddel_q[p]);
          sacc_d[p+1] = div_step(sacc_q[p], dmax_q[p]);
          ddel_d[p+1] = ddel_q[p];
          dmax_d[p+1] = dmax_q[p];
          dsec_d[p+1] = dsec_q[p];
          user_d[p+3] = user_q[p+2];
        end
      end
      if (valid_q[ND+1]) begin
        hq_d         = div_last(hacc_q[ND-1], ddel_q[ND-1]);
        sq_d         = div_last(sacc_q[ND-1], dmax_q[ND-1]);
        ddel_d[ND]   = ddel_q[ND-1];
        dmax_d[ND]   = dmax_q[ND-1];
        dsec_d[ND]   = dsec_q[ND-1];
        user_d[ND+2] = user_q[ND+1];
      end
      if (valid_q[L-2]) begin
        out_data_d  = {h_c, s_c, dmax_q[ND]};
        user_d[L-1] = user_q[L-2];
      end
    end
  end

  // Pipeline registers; reset clears valids, user sideband and all data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      r0_q       <= '0;
      g0_q       <= '0;
      b0_q       <= '0;
      max1_q     <= '0;
      delta1_q   <= '0;
      num1_q     <= '0;
      sec1_q     <= '0;
      hq_q       <= '0;
      sq_q       <= '0;
      out_data_q <= '0;
      for (int i = 0; i < L; i++) user_q[i] <= '0;
      for (int i = 0; i < ND; i++) begin
        hacc_q[i] <= '0;
        sacc_q[i] <= '0;
      end
      for (int i = 0; i <= ND; i++) begin
        ddel_q[i] <= '0;
        dmax_q[i] <= '0;
        dsec_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      user_q     <= user_d;
      r0_q       <= r0_d;
      g0_q       <= g0_d;
      b0_q       <= b0_d;
      max1_q     <= max1_d;
      delta1_q   <= delta1_d;
      num1_q     <= num1_d;
      sec1_q     <= sec1_d;
      hacc_q     <= hacc_d;
      sacc_q     <= sacc_d;
      ddel_q     <= ddel_d;
      dmax_q     <= dmax_d;
      dsec_q     <= dsec_d;
      hq_q       <= hq_d;
      sq_q       <= sq_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_rgb2hsv.sv
// Testbench for rgb2hsv: directed vectors, back-pressure burst, async reset
// mid-stream, HSV->RGB round trip and randomized pixels against a model.
module tb_rgb2hsv;

  localparam int W = 32;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic [2:0][7:0] in_data;
  logic [7:0]      in_user;
  logic            out_valid;
  logic [2:0][7:0] out_data;
  logic [7:0]      out_user;
  logic            in_ready;
  logic            out_ready;

  int              n_checks = 0;
  int              n_fail   = 0;
  int              n_out    = 0;
  logic [23:0]     last_out;
  logic            bp_en    = 1'b0;
  logic [W-1:0]    exp_q[$];
  logic            stalled  = 1'b0;
  logic [32:0]     stall_snap;

  rgb2hsv #(.RGB_DEPTH(8), .HSV_DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_user   (in_user),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_user  (out_user),
    .in_ready  (in_ready),
    .out_ready (out_ready)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  // downstream acceptance, randomized when bp_en is set
  initial begin
    in_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      in_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input int obs, input int exp);
    int d;
    d = obs - exp;
    if (d < 0) d = -d;
    n_checks++;
    assert (d <= 6) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d +/-6", tag, obs, exp);
    end
  endtask

  // reference model: HSV from the component rules with plain integer arithmetic
  function automatic logic [23:0] ref_hsv(input int r, input int g, input int b);
    int mx, mn, d, h, s, sector, num, frac, cap;
    mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
    mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
    d  = mx - mn;
    s  = (mx == 0) ? 0 : (255 * d) / mx;
    h  = 0;
    sector = 0;
    num    = 0;
    if (d != 0) begin
      if (r >= g && r >= b)  begin if (g >= b) begin sector = 0; num = g - b; end
                                   else        begin sector = 5; num = r - b; end end
      else if (g >= b)       begin if (b >= r) begin sector = 2; num = b - r; end
                                   else        begin sector = 1; num = g - r; end end
      else                   begin if (r >= g) begin sector = 4; num = r - g; end
                                   else        begin sector = 3; num = b - g; end end
      cap  = (sector == 5) ? 40 : 42;
      frac = (43 * num) / d;
      if (frac > cap) frac = cap;
      h = 43 * sector + frac;
    end
    return {h[7:0], s[7:0], mx[7:0]};
  endfunction

  // HSV-to-RGB conversion as done by the companion block
  task automatic hsv2rgb(input int h, input int s, input int v,
                         output int r, output int g, output int b);
    int region, rem, p, q, t;
    region = h / 43;
    rem    = (h - region * 43) * 6;
    p = (v * (255 - s)) >> 8;
    q = (v * (255 - ((s * rem) >> 8))) >> 8;
    t = (v * (255 - ((s * (255 - rem)) >> 8))) >> 8;
    case (region)
      0:       begin r = v; g = t; b = p; end
      1:       begin r = q; g = v; b = p; end
      2:       begin r = p; g = v; b = t; end
      3:       begin r = p; g = q; b = v; end
      4:       begin r = t; g = p; b = v; end
      default: begin r = v; g = p; b = q; end
    endcase
    if (s == 0) begin r = v; g = v; b = v; end
  endtask

  // driver: present one pixel until accepted, then queue its expected result
  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic [7:0] u, input logic [23:0] exp);
    logic ok;
    int   guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = {r, g, b};
    in_user  = u;
    do begin
      @(negedge clk);
      ok = out_ready;
      @(posedge clk);
      guard++;
    end while (!ok && guard < 1000);
    check("accept_timeout", {31'd0, ok}, 32'd1);
    exp_q.push_back({exp, u});
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic measure_latency(input string tag);
    int cnt;
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check(tag, cnt, 11);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 3000) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // scoreboard: compare each delivered beat, ready rule and stall stability
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) check("stall_hold", {31'd0, stall_snap[32]} ^ 32'd0, {31'd0, out_valid});
      if (stalled) check("stall_data", {out_data, out_user}, stall_snap[31:0]);
      check("ready_rule", {31'd0, out_ready}, {31'd0, (in_ready | ~out_valid)});
      if (out_valid && in_ready) begin
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_beat: observed %h expected none", {out_data, out_user});
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat", {out_data, out_user}, e);
          last_out = out_data;
          n_out++;
        end
      end
      stalled    = out_valid && !in_ready;
      stall_snap = {out_valid, out_data, out_user};
    end
  end

  // directed sequence
  initial begin
    int base_n, rr, gg, bb;
    logic [7:0] r, g, b;
    logic [7:0] rt_px [6][3];
    in_valid = 1'b0;
    in_data  = '0;
    in_user  = '0;
    reset    = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {8'd0, out_data},   32'd0);
    check("rst_out_user",  {24'd0, out_user},  32'd0);
    check("rst_out_ready", {31'd0, out_ready}, 32'd1);
    #2 reset = 1'b0;
    #1 check("post_rst_ready", {31'd0, out_ready}, 32'd1);
    idle(1);

    // primaries, with latency measured on the first beat after reset
    send(8'd255, 8'd0, 8'd0, 8'h01, {8'd0, 8'd255, 8'd255});
    measure_latency("latency_first");
    wait_drain();
    send(8'd0, 8'd255, 8'd0, 8'h02, {8'd86, 8'd255, 8'd255});
    send(8'd0, 8'd0, 8'd255, 8'h03, {8'd172, 8'd255, 8'd255});
    // greys, interior and S5 saturation
    send(8'd128, 8'd128, 8'd128, 8'h04, {8'd0, 8'd0, 8'd128});
    send(8'd0, 8'd0, 8'd0, 8'h05, {8'd0, 8'd0, 8'd0});
    send(8'd255, 8'd128, 8'd0, 8'h06, {8'd21, 8'd255, 8'd255});
    send(8'd255, 8'd0, 8'd1, 8'h07, {8'd255, 8'd255, 8'd255});
    send(8'd1, 8'd0, 8'd0, 8'h08, ref_hsv(1, 0, 0));
    send(8'd255, 8'd255, 8'd0, 8'h09, ref_hsv(255, 255, 0));
    wait_drain();

    // back-pressure burst
    bp_en  = 1'b1;
    base_n = n_out;
    for (int i = 0; i < 20; i++) begin
      r = 8'($urandom_range(0, 255));
      g = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      send(r, g, b, 8'(i), ref_hsv(r, g, b));
    end
    wait_drain();
    check("burst_count", n_out - base_n, 20);

    // randomized pixels with random gaps and back-pressure
    for (int i = 0; i < 150; i++) begin
      r = 8'($urandom_range(0, 255));
      g = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 4))
        0: g = r;
        1: b = g;
        2: b = r;
        default: ;
      endcase
      send(r, g, b, 8'($urandom_range(0, 255)), ref_hsv(r, g, b));
      idle($urandom_range(0, 2));
    end
    wait_drain();

    // asynchronous reset with 5 beats in flight
    bp_en = 1'b0;
    idle(1);
    wait_drain();
    for (int i = 0; i < 5; i++) send(8'd200, 8'(40 * i), 8'd10, 8'(100 + i), ref_hsv(200, 40 * i, 10));
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_data",  {8'd0, out_data},   32'd0);
    check("arst_out_user",  {24'd0, out_user},  32'd0);
    check("arst_out_ready", {31'd0, out_ready}, 32'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1 check("arst_release_ready", {31'd0, out_ready}, 32'd1);
    idle(15);
    send(8'd10, 8'd20, 8'd200, 8'h55, ref_hsv(10, 20, 200));
    measure_latency("latency_after_reset");
    wait_drain();

    // round trip through the HSV-to-RGB conversion
    rt_px = '{'{8'd255, 8'd0, 8'd0},   '{8'd255, 8'd255, 8'd0}, '{8'd0, 8'd255, 8'd0},
              '{8'd0, 8'd255, 8'd255}, '{8'd0, 8'd0, 8'd255},   '{8'd255, 8'd0, 8'd255}};
    for (int i = 0; i < 6; i++) begin
      int guard;
      base_n = n_out;
      send(rt_px[i][0], rt_px[i][1], rt_px[i][2], 8'(200 + i),
           ref_hsv(rt_px[i][0], rt_px[i][1], rt_px[i][2]));
      guard = 0;
      while (n_out == base_n && guard < 100) begin
        @(posedge clk);
        #1;
        guard++;
      end
      check("rt_timeout", {31'd0, (n_out != base_n)}, 32'd1);
      hsv2rgb(last_out[23:16], last_out[15:8], last_out[7:0], rr, gg, bb);
      check_tol("rt_r", rr, rt_px[i][0]);
      check_tol("rt_g", gg, rt_px[i][1]);
      check_tol("rt_b", bb, rt_px[i][2]);
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb2hsv.md
RGB2HSV -- requirements
Module: rgb2hsv

Interface
REQ-001 Parameter RGB_DEPTH, default 8, input component width; only 8 is supported.
REQ-002 Parameter HSV_DEPTH, default 8, output component width; only 8 is supported.
REQ-003 clk  input  1  rising-edge clock; sole clock domain.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  input beat valid.
REQ-006 in_data  input  [3] x RGB_DEPTH  [2]=R, [1]=G, [0]=B.
REQ-007 in_user  input  8  sideband; travels with the pixel.
REQ-008 out_valid  output  1  output beat valid.
REQ-009 out_data  output  [3] x HSV_DEPTH  [2]=H, [1]=S, [0]=V; same coding as consumed by the HSV-to-RGB block.
REQ-010 out_user  output  8  in_user of the pixel on out_data.
REQ-011 in_ready  input  1  downstream can accept.
REQ-012 out_ready  output  1  this block can accept.

Function
REQ-013 Fixed pipeline of L=12 stages: input register, max/min/sector, products, 8 divider stages, assembly.
REQ-014 Define run = in_ready OR NOT valid[L-1]; out_ready = run, combinationally.
REQ-015 When run=1, the valid shift register advances with in_valid entering; when run=0, every pipeline register, out_data and out_user hold.
REQ-016 Stage data and user register only when their stage valid is 1; bubbles leave data registers unchanged.
REQ-017 out_valid = valid[L-1]; out_data and out_user are registered and change only when the last stage loads.
REQ-018 A beat accepted (in_valid=1, run=1) at edge n appears at edge n+L-1 if run stays high, in order, with no loss or duplication.
REQ-019 max = max(R,G,B), min = min(R,G,B), delta = max-min, all 8-bit unsigned.
REQ-020 Sector select, first match wins: R>=G and R>=B -> (G>=B ? S0 : S5); else G>=B -> (B>=R ? S2 : S1); else -> (R>=G ? S4 : S3).
REQ-021 Numerator num per sector: S0=G-B, S1=G-R, S2=B-R, S3=B-G, S4=R-G, S5=R-B; always 0..delta.
REQ-022 Sector base per sector S0..S5: 0, 43, 86, 129, 172, 215.
REQ-023 frac = floor(43*num/delta), saturated to 42 for S0..S4 and to 40 for S5.
REQ-024 H = base + frac; H is never above 255.
REQ-025 S = floor(255*delta/max).
REQ-026 V = max.
REQ-027 Divisions use a pipelined restoring divider: 16-bit numerator, 8-bit divisor, one quotient bit per stage, MSB first, 8 stages.
REQ-028 delta=0 forces H=0 and S=0; max=0 forces S=0; divide-by-zero results are never used.
REQ-029 No intermediate value truncates before the final saturation of REQ-023.

Reset
REQ-030 While reset is high, all valid bits = 0, out_valid = 0, out_data = {0,0,0}, out_user = 0, and all user pipeline registers = 0.
REQ-031 Reset asserted mid-stream discards all in-flight beats.
REQ-032 The first beat accepted after reset release obeys REQ-018.
REQ-033 out_ready is 1 during and immediately after reset.

Verification
REQ-034 Primaries, in_ready=1 -> 11 edges after acceptance: (255,0,0) -> H0 S255 V255; (0,255,0) -> H86 S255 V255; (0,0,255) -> H172 S255 V255.
REQ-035 Greys -> (128,128,128) gives H0 S0 V128; (0,0,0) gives H0 S0 V0, with no X values on out_data.
REQ-036 Interior and saturation -> (255,128,0) gives H21 S255 V255; (255,0,1) gives S5, frac saturated to 40, H255.
REQ-037 Back-pressure: 20-beat burst with in_user = beat index, in_ready toggled pseudo-randomly -> out_ready = 0 exactly when out_valid=1 and in_ready=0; outputs stable while stalled; all 20 beats in order with matching user.
REQ-038 Reset asserted asynchronously (between edges) with 5 beats in flight -> out_valid = 0 and outputs zero immediately; no stale beat appears after release.
REQ-039 Round trip: all 6 sector bases at V=255, S=255 through this block then the HSV-to-RGB block -> each RGB component within +/-6 LSB of input.
